// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed N-digit hex display driver.
// A shadow register holds the displayed value and decimal points. The digits
// are scanned one at a time at a programmable refresh rate. Each digit can be
// blanked, blinked or hidden as a leading zero. Segment, dp and digit enable
// outputs are registered and take the configured polarity.
module seven_segment_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

    // Hex nibble to segment pattern, active-low, bit6..bit0 = g..a.
    function automatic logic [6:0] hex_to_seg_al(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow_value_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [RW-1:0]           refresh_cnt_r;
    logic [IW-1:0]           scan_idx_r;
    logic [BW-1:0]           blink_cnt_r;
    logic                    blink_on_r;
    logic                    wrap_d_r;
    logic                    frame_done_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   digit_en_r;

    logic                    refresh_tc_s;
    logic                    idx_last_s;
    logic                    blink_tc_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    cur_blank_s;
    logic                    cur_blink_s;
    logic                    upper_nz_s;
    logic                    lz_dark_s;
    logic                    dark_s;
    logic [6:0]              seg_al_s;
    logic                    dp_al_s;
    logic [NUM_DIGITS-1:0]   en_al_s;

    assign refresh_tc_s = (refresh_cnt_r == RW'(REFRESH_DIV - 1));
    assign idx_last_s   = (scan_idx_r == IW'(NUM_DIGITS - 1));
    assign blink_tc_s   = (blink_cnt_r == BW'(BLINK_DIV - 1));
    assign wrap_s       = refresh_tc_s & idx_last_s;

    // Shadow capture of value and decimal points; scan timing is not touched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r    <= {NUM_DIGITS{1'b0}};
        end else if (load) begin
            shadow_value_r <= value;
            shadow_dp_r    <= dp_mask;
        end else begin
            shadow_value_r <= shadow_value_r;
            shadow_dp_r    <= shadow_dp_r;
        end
    end

    // Refresh divider; each terminal count moves the scan to the next digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_r <= {RW{1'b0}};
            scan_idx_r    <= {IW{1'b0}};
        end else if (refresh_tc_s) begin
            refresh_cnt_r <= {RW{1'b0}};
            scan_idx_r    <= idx_last_s ? {IW{1'b0}} : scan_idx_r + IW'(1);
        end else begin
            refresh_cnt_r <= refresh_cnt_r + RW'(1);
            scan_idx_r    <= scan_idx_r;
        end
    end

    // Free-running blink divider toggling the blink phase at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= 1'b1;
        end else if (blink_tc_s) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= ~blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
            blink_on_r  <= blink_on_r;
        end
    end

    // Frame pulse delayed one cycle past the index wrap to line up with the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_d_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            wrap_d_r     <= wrap_s;
            frame_done_r <= wrap_d_r;
        end
    end

    // Select the current digit's data and decide whether it stays dark.
    always_comb begin
        sel_s       = {NUM_DIGITS{1'b0}};
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        cur_blink_s = 1'b0;
        upper_nz_s  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_s[k]    = (scan_idx_r == IW'(k));
            cur_nib_s   = cur_nib_s | (shadow_value_r[4*k +: 4] & {4{sel_s[k]}});
            cur_dp_s    = cur_dp_s | (shadow_dp_r[k] & sel_s[k]);
            cur_blank_s = cur_blank_s | (blank_mask[k] & sel_s[k]);
            cur_blink_s = cur_blink_s | (blink_mask[k] & sel_s[k]);
            // Any non-zero nibble at or above the current digit keeps it visible.
            upper_nz_s  = upper_nz_s | ((scan_idx_r <= IW'(k)) &
                                        (shadow_value_r[4*k +: 4] != 4'h0));
        end
        lz_dark_s = lz_suppress & (scan_idx_r != {IW{1'b0}}) & ~upper_nz_s;
        dark_s    = cur_blank_s | (cur_blink_s & ~blink_on_r) | lz_dark_s;
        seg_al_s  = dark_s ? 7'h7F : hex_to_seg_al(cur_nib_s);
        dp_al_s   = dark_s ? 1'b1 : ~cur_dp_s;
        en_al_s   = dark_s ? {NUM_DIGITS{1'b1}} : ~sel_s;
    end

    // Registered display outputs with the configured polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r      <= SEG_OFF;
            dp_r       <= DP_OFF;
            digit_en_r <= EN_OFF;
        end else if (ACTIVE_LOW != 0) begin
            seg_r      <= seg_al_s;
            dp_r       <= dp_al_s;
            digit_en_r <= en_al_s;
        end else begin
            seg_r      <= ~seg_al_s;
            dp_r       <= ~dp_al_s;
            digit_en_r <= ~en_al_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign digit_en   = digit_en_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Testbench for seven_segment_scan: a 4-digit active-low instance and a
// 1-digit active-high instance, checked cycle by cycle against a scoreboard.
module tb_seven_segment_scan;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 digits, REFRESH_DIV 4, BLINK_DIV 16, active-low
    logic        rst_a;
    logic [15:0] value_a;
    logic        load_a;
    logic [3:0]  dp_mask_a, blank_a, blink_a;
    logic        lz_a;
    logic [6:0]  seg_a;
    logic        dp_a;
    logic [3:0]  digit_en_a;
    logic        frame_done_a;

    // Instance B: 1 digit, REFRESH_DIV 1, BLINK_DIV 4, active-high
    logic        rst_b;
    logic [3:0]  value_b;
    logic        load_b;
    logic [0:0]  dp_mask_b, blank_b, blink_b;
    logic        lz_b;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic [0:0]  digit_en_b;
    logic        frame_done_b;

    seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst_a), .value(value_a), .load(load_a), .dp_mask(dp_mask_a),
        .blank_mask(blank_a), .blink_mask(blink_a), .lz_suppress(lz_a),
        .seg(seg_a), .dp(dp_a), .digit_en(digit_en_a), .frame_done(frame_done_a)
    );

    seven_segment_scan #(.NUM_DIGITS(1), .REFRESH_DIV(1), .BLINK_DIV(4), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst_b), .value(value_b), .load(load_b), .dp_mask(dp_mask_b),
        .blank_mask(blank_b), .blink_mask(blink_b), .lz_suppress(lz_b),
        .seg(seg_b), .dp(dp_b), .digit_en(digit_en_b), .frame_done(frame_done_b)
    );

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   ta = 0;
    int   tb_cnt = 0;
    bit   run_a = 1'b0;
    bit   run_b = 1'b0;
    logic [15:0] sh_a   = 16'h0;
    logic [3:0]  shdp_a = 4'h0;
    logic [3:0]  sh_b   = 4'h0;
    logic        shdp_b = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected output after edge t (counted from reset release).
    function automatic exp_t model_out(input int t, input int n, input int r, input int bdiv,
                                       input bit al, input logic [31:0] sh, input logic [7:0] shdp,
                                       input logic [7:0] blank, input logic [7:0] blink, input bit lz);
        exp_t        e;
        int          k;
        bit          phase_on;
        bit          dark;
        logic [31:0] upper;
        logic [3:0]  nib;
        logic [7:0]  mask;
        k        = ((t - 1) / r) % n;
        phase_on = (((t - 1) / bdiv) % 2) == 0;
        upper    = sh >> (4 * k);
        nib      = upper[3:0];
        dark     = blank[k] || (blink[k] && !phase_on) || (lz && (k > 0) && (upper == 32'h0));
        if (dark) begin
            e.en  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.en  = ~(8'h01 << k);
            e.seg = SEG_TBL[nib];
            e.dp  = ~shdp[k];
        end
        if (!al) begin
            e.en  = ~e.en;
            e.seg = ~e.seg;
            e.dp  = ~e.dp;
        end
        mask = (8'h01 << n) - 8'h01;
        e.en = e.en & mask;
        e.fd = (t >= 2) && (((t - 1) % (r * n)) == 0);
        return e;
    endfunction

    // One clock: push expectations, take the edge, then pop and compare.
    task automatic tick();
        exp_t e;
        if (run_a) begin
            ta++;
            q_a.push_back(model_out(ta, 4, 4, 16, 1'b1, {16'h0, sh_a}, {4'h0, shdp_a},
                                    {4'h0, blank_a}, {4'h0, blink_a}, lz_a));
        end
        if (run_b) begin
            tb_cnt++;
            q_b.push_back(model_out(tb_cnt, 1, 1, 4, 1'b0, {28'h0, sh_b}, {7'h0, shdp_b},
                                    {7'h0, blank_b}, {7'h0, blink_b}, lz_b));
        end
        @(posedge clk);
        if (run_a && load_a) begin
            sh_a   = value_a;
            shdp_a = dp_mask_a;
        end
        if (run_b && load_b) begin
            sh_b   = value_b;
            shdp_b = dp_mask_b[0];
        end
        #1;
        if (run_a && q_a.size() > 0) begin
            e = q_a.pop_front();
            check_value("a_digit_en", {28'h0, digit_en_a}, {28'h0, e.en[3:0]});
            check_value("a_seg", {25'h0, seg_a}, {25'h0, e.seg});
            check_value("a_dp", {31'h0, dp_a}, {31'h0, e.dp});
            check_value("a_frame_done", {31'h0, frame_done_a}, {31'h0, e.fd});
        end
        if (run_b && q_b.size() > 0) begin
            e = q_b.pop_front();
            check_value("b_digit_en", {31'h0, digit_en_b}, {31'h0, e.en[0]});
            check_value("b_seg", {25'h0, seg_b}, {25'h0, e.seg});
            check_value("b_dp", {31'h0, dp_b}, {31'h0, e.dp});
            check_value("b_frame_done", {31'h0, frame_done_b}, {31'h0, e.fd});
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_a_val(input logic [15:0] v, input logic [3:0] d);
        value_a   = v;
        dp_mask_a = d;
        load_a    = 1'b1;
        tick();
        load_a    = 1'b0;
    endtask

    task automatic check_a_dark(input string tag);
        check_value({tag, "_seg"}, {25'h0, seg_a}, 32'h7F);
        check_value({tag, "_dp"}, {31'h0, dp_a}, 32'h1);
        check_value({tag, "_en"}, {28'h0, digit_en_a}, 32'hF);
        check_value({tag, "_fd"}, {31'h0, frame_done_a}, 32'h0);
    endtask

    initial begin
        value_a = 16'h0; load_a = 1'b0; dp_mask_a = 4'h0; blank_a = 4'h0; blink_a = 4'h0; lz_a = 1'b0;
        value_b = 4'h0;  load_b = 1'b0; dp_mask_b = 1'b0; blank_b = 1'b0; blink_b = 1'b0; lz_b = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        // Reset state of both instances
        check_a_dark("rst_a");
        check_value("rst_b_seg", {25'h0, seg_b}, 32'h0);
        check_value("rst_b_dp", {31'h0, dp_b}, 32'h0);
        check_value("rst_b_en", {31'h0, digit_en_b}, 32'h0);
        check_value("rst_b_fd", {31'h0, frame_done_b}, 32'h0);
        #1;
        rst_a = 1'b0;
        run_a = 1'b1;

        // Basic scan of 12AF, several frames
        load_a_val(16'h12AF, 4'h0);
        run_cycles(40);

        // Leading-zero suppression
        lz_a = 1'b1;
        load_a_val(16'h0040, 4'h0);
        run_cycles(20);
        load_a_val(16'h0000, 4'h0);
        run_cycles(20);
        lz_a = 1'b0;

        // Blink on digit 0, decimal points on digits 0 and 2
        blink_a = 4'b0001;
        load_a_val(16'h8888, 4'b0101);
        run_cycles(64);
        blink_a = 4'b0000;

        // Blanking and remaining glyphs
        blank_a = 4'b0100;
        load_a_val(16'h69BE, 4'h0);
        run_cycles(20);
        blank_a = 4'b0000;
        load_a_val(16'hD000, 4'b1000);
        run_cycles(20);

        // Load in the middle of a digit slot
        run_cycles(2);
        load_a_val(16'h5A3C, 4'h0);
        run_cycles(20);

        // Asynchronous reset between edges
        rst_a = 1'b1;
        #1;
        check_a_dark("async_rst_a");
        #2;
        rst_a  = 1'b0;
        ta     = 0;
        sh_a   = 16'h0;
        shdp_a = 4'h0;
        q_a.delete();
        run_cycles(20);

        // Single digit, active-high, refresh every cycle
        run_a  = 1'b0;
        rst_b  = 1'b0;
        run_b  = 1'b1;
        value_b   = 4'h7;
        dp_mask_b = 1'b1;
        load_b    = 1'b1;
        tick();
        load_b    = 1'b0;
        run_cycles(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
Parametrised, time-multiplexed multi-digit hex display driver; successor to the single-digit combinational hex decoder. Captures an N-digit hex value into a shadow register and scans digits one at a time at a programmable refresh rate. Adds per-digit blanking, blinking, decimal points and leading-zero suppression. Drives shared segment lines plus per-digit enables, for counter, score and timer displays.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 50000, clock cycles each digit is held (legal >= 1)
BLINK_DIV, 25000000, clock cycles per blink half-period (legal >= 1)
ACTIVE_LOW, 1, 1 = seg/dp/digit_en active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
value  in  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0] (rightmost)
load  in  1  capture value/dp_mask into shadow on this clock edge
dp_mask  in  NUM_DIGITS  decimal point on per digit (captured with load)
blank_mask  in  NUM_DIGITS  1 = digit always dark (live, not captured)
blink_mask  in  NUM_DIGITS  1 = digit dark during blink-off phase (live)
lz_suppress  in  1  1 = suppress leading zeros (live)
seg  out  7  segments; bit0=a(top), 1=b, 2=c, 3=d, 4=e, 5=f, 6=g(middle)
dp  out  1  decimal point segment
digit_en  out  NUM_DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset (async, immediate): shadow value/dp = 0; scan index = 0; refresh counter = 0; blink counter = 0; blink phase = on; seg, dp, digit_en all inactive (active-low: seg = 7'h7F, dp = 1, digit_en all 1s); frame_done = 0.
- Shadow: on a clock edge with load = 1, shadow <= value, dp_mask. Scan is not restarted. Decoded outputs use the new shadow from the next edge. rst overrides load.
- Refresh counter: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances. Index NUM_DIGITS-1 wraps to 0. With REFRESH_DIV = 1, the index advances every cycle.
- frame_done: registered. High for exactly one cycle on the edge after the index wraps NUM_DIGITS-1 -> 0.
- Blink counter: counts 0..BLINK_DIV-1. At terminal count the blink phase toggles. Free-running, independent of scan.
- Outputs: registered, one cycle latency from scan index/shadow to seg/dp/digit_en. Each digit is driven for exactly REFRESH_DIV consecutive cycles per frame.
- Digit k is dark if any of the following holds:
  - blank_mask[k] = 1;
  - blink_mask[k] = 1 and blink phase = off;
  - lz_suppress = 1, k > 0, and shadow nibbles k..NUM_DIGITS-1 are all zero.
  Digit 0 is never suppressed as a leading zero.
- Dark digit: digit_en all inactive, seg and dp inactive.
- Lit digit: exactly one digit_en bit active (bit k); seg = decode(nibble k); dp = shadow dp bit k.
- Decode, active-low form (bit6..bit0 = g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  With ACTIVE_LOW = 0, seg/dp/digit_en are bitwise inverted.
- Never more than one digit_en bit active in any cycle.
- Counter widths: $clog2 of the divisor, minimum 1 bit. No combinational path from inputs to outputs.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=4: reset, load value=16'h12AF -> digit_en (active-low) cycles 1110,1101,1011,0111, 4 cycles each; seg = 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1); frame_done pulses once per 16 cycles.
2. lz_suppress=1, load 16'h0040 -> digits 3 and 2 dark, digit 1 = 0011001 (4), digit 0 = 1000000. Load 16'h0000 -> only digit 0 lit, showing 0.
3. BLINK_DIV=16, blink_mask=4'b0001, value 16'h8888 -> digit 0 lit for 16 cycles, then dark for 16 cycles, repeating; digits 1-3 always lit with seg = 0000000.
4. Assert load with a new value mid-digit -> scan timing unchanged; new nibble appears one cycle after the load edge; no frame restart.
5. Assert rst mid-scan (asynchronous, between edges) -> outputs go inactive immediately, with no clock edge needed; after release, scan resumes at digit 0 with shadow = 0.
6. ACTIVE_LOW=0, REFRESH_DIV=1, NUM_DIGITS=1, dp_mask=1, value=4'h7 -> digit_en = 1 every cycle, seg = 0000111, dp = 1, frame_done high every cycle after the first.
